// File: rtl/cfu_sha_sigma.sv
// cfu_sha_sigma: pipelined SHA-256/SHA-512 sigma CFU with a valid/ready handshake.
// Optional macro CFU_SHA_SIGMA_ID_EN adds a 4-bit request ID carried alongside each result.
module cfu_sha_sigma #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_func,
    input  logic [DATA_WIDTH-1:0] req_data,
`ifdef CFU_SHA_SIGMA_ID_EN
    input  logic [3:0]            req_id,
    output logic [3:0]            resp_id,
`endif
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("cfu_sha_sigma: DATA_WIDTH must be 32 or 64");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("cfu_sha_sigma: LATENCY must be in 1..4");
    end

    // The third term of sig0/sig1 is a logical shift; for Sum0/Sum1 it is a rotate.
    localparam bit WIDE = (DATA_WIDTH == 64);
    localparam int S0A = WIDE ? 1  : 7;
    localparam int S0B = WIDE ? 8  : 18;
    localparam int S0C = WIDE ? 7  : 3;
    localparam int S1A = WIDE ? 19 : 17;
    localparam int S1B = WIDE ? 61 : 19;
    localparam int S1C = WIDE ? 6  : 10;
    localparam int B0A = WIDE ? 28 : 2;
    localparam int B0B = WIDE ? 34 : 13;
    localparam int B0C = WIDE ? 39 : 22;
    localparam int B1A = WIDE ? 14 : 6;
    localparam int B1B = WIDE ? 18 : 11;
    localparam int B1C = WIDE ? 41 : 25;

    function automatic logic [DATA_WIDTH-1:0] ror(input logic [DATA_WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    logic [DATA_WIDTH-1:0] sigma;
    logic                  stage_valid [LATENCY];
    logic [DATA_WIDTH-1:0] stage_data  [LATENCY];
    logic                  adv;

    always_comb begin
        sigma = '0;
        case (req_func)
            2'd0: sigma = ror(req_data, S0A) ^ ror(req_data, S0B) ^ (req_data >> S0C);
            2'd1: sigma = ror(req_data, S1A) ^ ror(req_data, S1B) ^ (req_data >> S1C);
            2'd2: sigma = ror(req_data, B0A) ^ ror(req_data, B0B) ^ ror(req_data, B0C);
            2'd3: sigma = ror(req_data, B1A) ^ ror(req_data, B1B) ^ ror(req_data, B1C);
            default: sigma = '0;
        endcase
    end

    // Single global stall: every stage moves only when the output slot can drain.
    assign adv        = !stage_valid[LATENCY-1] || resp_ready;
    assign req_ready  = adv;
    assign resp_valid = stage_valid[LATENCY-1];
    assign resp_data  = stage_data[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_valid[i] <= 1'b0;
                stage_data[i]  <= '0;
            end
        end else if (adv) begin
            stage_valid[0] <= req_valid;
            if (req_valid) begin
                stage_data[0] <= sigma;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                if (stage_valid[i-1]) begin
                    stage_data[i] <= stage_data[i-1];
                end
            end
        end
    end

`ifdef CFU_SHA_SIGMA_ID_EN
    logic [3:0] stage_id [LATENCY];

    assign resp_id = stage_id[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_id[i] <= '0;
            end
        end else if (adv) begin
            if (req_valid) begin
                stage_id[0] <= req_id;
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (stage_valid[i-1]) begin
                    stage_id[i] <= stage_id[i-1];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cfu_sha_sigma.sv
// tb_cfu_sha_sigma: self-checking bench for cfu_sha_sigma, one 32-bit LATENCY=3 instance
// and one 64-bit LATENCY=1 instance, driven with directed tables plus random traffic.
module tb_cfu_sha_sigma;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [1:0]  a_req_func;
    logic [31:0] a_req_data, a_resp_data;
    logic [3:0]  a_req_id;
    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [1:0]  b_req_func;
    logic [63:0] b_req_data, b_resp_data;
    logic [3:0]  b_req_id;
`ifdef CFU_SHA_SIGMA_ID_EN
    logic [3:0]  a_resp_id, b_resp_id;
`endif

    cfu_sha_sigma #(.DATA_WIDTH(32), .LATENCY(3)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_func(a_req_func), .req_data(a_req_data),
`ifdef CFU_SHA_SIGMA_ID_EN
        .req_id(a_req_id), .resp_id(a_resp_id),
`endif
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data)
    );

    cfu_sha_sigma #(.DATA_WIDTH(64), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_func(b_req_func), .req_data(b_req_data),
`ifdef CFU_SHA_SIGMA_ID_EN
        .req_id(b_req_id), .resp_id(b_resp_id),
`endif
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data)
    );

    typedef struct {
        logic [1:0]  func;
        logic [63:0] data;
        logic [63:0] expected;
    } vec_t;

    vec_t vec32 [12];
    vec_t vec64 [8];

    int checks = 0;
    int errors = 0;

    logic [31:0] a_exp_q [$];
    logic [63:0] b_exp_q [$];
    logic [3:0]  a_id_q  [$];
    logic [3:0]  b_id_q  [$];
    logic [31:0] a_cur_exp;
    logic [63:0] b_cur_exp;
    logic        a_prev_stall, b_prev_stall;
    logic [31:0] a_prev_data;
    logic [63:0] b_prev_data;
    int          a_resp_count = 0;
    int          b_resp_count = 0;
    bit          rand_done;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input logic [63:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %h, required no event", name, actual);
    endtask

    // Independent reference: bitwise rotate built from index arithmetic.
    function automatic logic [63:0] ror_ref(input logic [63:0] x, input int w, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = x[(i + n) % w];
        return r;
    endfunction

    function automatic logic [63:0] sigma_ref(input int w, input logic [1:0] f, input logic [63:0] x);
        int a, b, c;
        logic [63:0] third;
        if (w == 32) begin
            case (f)
                2'd0: begin a = 7;  b = 18; c = 3;  end
                2'd1: begin a = 17; b = 19; c = 10; end
                2'd2: begin a = 2;  b = 13; c = 22; end
                default: begin a = 6; b = 11; c = 25; end
            endcase
        end else begin
            case (f)
                2'd0: begin a = 1;  b = 8;  c = 7;  end
                2'd1: begin a = 19; b = 61; c = 6;  end
                2'd2: begin a = 28; b = 34; c = 39; end
                default: begin a = 14; b = 18; c = 41; end
            endcase
        end
        third = (f < 2'd2) ? (x >> c) : ror_ref(x, w, c);
        return ror_ref(x, w, a) ^ ror_ref(x, w, b) ^ third;
    endfunction

    // Per-cycle protocol monitor for instance A (mid-cycle sampling).
    always @(negedge clk) begin
        if (rst) begin
            a_prev_stall <= 1'b0;
        end else begin
            check_output("a_req_ready_rule", a_req_ready, !(a_resp_valid && !a_resp_ready));
            if (a_prev_stall) begin
                check_output("a_stall_valid_held", a_resp_valid, 1'b1);
                check_output("a_stall_data_held", a_resp_data, a_prev_data);
            end
            if (a_req_valid && a_req_ready) begin
                a_exp_q.push_back(a_cur_exp);
                a_id_q.push_back(a_req_id);
            end
            if (a_resp_valid && a_resp_ready) begin
                a_resp_count <= a_resp_count + 1;
                if (a_exp_q.size() == 0) begin
                    report_fail("a_unexpected_resp", a_resp_data);
                end else begin
                    check_output("a_resp_data", a_resp_data, a_exp_q.pop_front());
`ifdef CFU_SHA_SIGMA_ID_EN
                    check_output("a_resp_id", a_resp_id, a_id_q.pop_front());
`else
                    void'(a_id_q.pop_front());
`endif
                end
            end
            a_prev_stall <= a_resp_valid && !a_resp_ready;
            a_prev_data  <= a_resp_data;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_prev_stall <= 1'b0;
        end else begin
            check_output("b_req_ready_rule", b_req_ready, !(b_resp_valid && !b_resp_ready));
            if (b_prev_stall) begin
                check_output("b_stall_valid_held", b_resp_valid, 1'b1);
                check_output("b_stall_data_held", b_resp_data, b_prev_data);
            end
            if (b_req_valid && b_req_ready) begin
                b_exp_q.push_back(b_cur_exp);
                b_id_q.push_back(b_req_id);
            end
            if (b_resp_valid && b_resp_ready) begin
                b_resp_count <= b_resp_count + 1;
                if (b_exp_q.size() == 0) begin
                    report_fail("b_unexpected_resp", b_resp_data);
                end else begin
                    check_output("b_resp_data", b_resp_data, b_exp_q.pop_front());
`ifdef CFU_SHA_SIGMA_ID_EN
                    check_output("b_resp_id", b_resp_id, b_id_q.pop_front());
`else
                    void'(b_id_q.pop_front());
`endif
                end
            end
            b_prev_stall <= b_resp_valid && !b_resp_ready;
            b_prev_data  <= b_resp_data;
        end
    end

    // Drive one request on A and hold it until accepted; returns at posedge+1.
    task automatic apply_stimulus_a(input logic [1:0] f, input logic [31:0] d, input logic [31:0] e, input logic [3:0] id);
        int waited;
        waited = 0;
        a_req_valid = 1'b1;
        a_req_func  = f;
        a_req_data  = d;
        a_cur_exp   = e;
        a_req_id    = id;
        @(negedge clk);
        while (!a_req_ready) begin
            waited++;
            if (waited > 100) begin
                report_fail("a_accept_timeout", d);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
    endtask

    task automatic apply_stimulus_b(input logic [1:0] f, input logic [63:0] d, input logic [63:0] e, input logic [3:0] id);
        int waited;
        waited = 0;
        b_req_valid = 1'b1;
        b_req_func  = f;
        b_req_data  = d;
        b_cur_exp   = e;
        b_req_id    = id;
        @(negedge clk);
        while (!b_req_ready) begin
            waited++;
            if (waited > 100) begin
                report_fail("b_accept_timeout", d);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 300 && (a_exp_q.size() != 0 || b_exp_q.size() != 0); k++) @(negedge clk);
        check_output({name, "_a_pending"}, a_exp_q.size(), 0);
        check_output({name, "_b_pending"}, b_exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] t;
        logic [1:0]  f;
        logic [31:0] d32;
        logic [63:0] d64;
        int          cnt;

        vec32[0]  = '{2'd0, 64'h1,        64'h02004000};
        vec32[1]  = '{2'd1, 64'h1,        64'h0000A000};
        vec32[2]  = '{2'd2, 64'h1,        64'h40080400};
        vec32[3]  = '{2'd3, 64'h1,        64'h04200080};
        vec32[4]  = '{2'd0, 64'h80000000, 64'h11002000};
        vec32[5]  = '{2'd1, 64'h80000000, 64'h00205000};
        vec32[6]  = '{2'd2, 64'h80000000, 64'h20040200};
        vec32[7]  = '{2'd3, 64'h80000000, 64'h02100040};
        vec32[8]  = '{2'd0, 64'hFFFFFFFF, 64'h1FFFFFFF};
        vec32[9]  = '{2'd1, 64'hFFFFFFFF, 64'h003FFFFF};
        vec32[10] = '{2'd2, 64'hFFFFFFFF, 64'hFFFFFFFF};
        vec32[11] = '{2'd3, 64'hFFFFFFFF, 64'hFFFFFFFF};
        vec64[0]  = '{2'd0, 64'h1, 64'h8100000000000000};
        vec64[1]  = '{2'd1, 64'h1, 64'h0000200000000008};
        vec64[2]  = '{2'd2, 64'h1, 64'h0000001042000000};
        vec64[3]  = '{2'd3, 64'h1, 64'h0004400000800000};
        vec64[4]  = '{2'd0, 64'h8000000000000000, 64'h4180000000000000};
        vec64[5]  = '{2'd1, 64'h8000000000000000, 64'h0200100000000004};
        vec64[6]  = '{2'd0, 64'hFFFFFFFFFFFFFFFF, 64'h01FFFFFFFFFFFFFF};
        vec64[7]  = '{2'd1, 64'hFFFFFFFFFFFFFFFF, 64'h03FFFFFFFFFFFFFF};

        rst = 1'b1;
        a_req_valid = 1'b0; a_req_func = '0; a_req_data = '0; a_req_id = '0; a_resp_ready = 1'b1; a_cur_exp = '0;
        b_req_valid = 1'b0; b_req_func = '0; b_req_data = '0; b_req_id = '0; b_resp_ready = 1'b1; b_cur_exp = '0;
        #7;
        check_output("a_reset_resp_valid", a_resp_valid, 1'b0);
        check_output("a_reset_resp_data", a_resp_data, 32'h0);
        check_output("a_reset_req_ready", a_req_ready, 1'b1);
        check_output("b_reset_resp_valid", b_resp_valid, 1'b0);
        check_output("b_reset_resp_data", b_resp_data, 64'h0);
        check_output("b_reset_req_ready", b_req_ready, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] latency: B (LATENCY=1) responds right after the accepting edge");
        b_req_valid = 1'b1; b_req_func = 2'd1; b_req_data = 64'h1; b_cur_exp = 64'h0000200000000008; b_req_id = 4'd5;
        @(negedge clk);
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        check_output("b_latency_1", b_resp_valid, 1'b1);
        @(posedge clk);
        #1;

        $display("[TB] latency: A (LATENCY=3) responds two edges after the accepting edge");
        a_req_valid = 1'b1; a_req_func = 2'd0; a_req_data = 32'h1; a_cur_exp = 32'h02004000; a_req_id = 4'd7;
        @(negedge clk);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("a_latency_k%0d", k), a_resp_valid, k == 2);
        end
        @(posedge clk);
        #1;

        $display("[TB] table vectors back-to-back");
        for (int i = 0; i < 12; i++) apply_stimulus_a(vec32[i].func, vec32[i].data[31:0], vec32[i].expected[31:0], 4'(i));
        for (int i = 0; i < 8; i++) apply_stimulus_b(vec64[i].func, vec64[i].data, vec64[i].expected, 4'(i));
        drain("table");

        $display("[TB] stall: 6 requests on A, resp_ready low for three cycles");
        cnt = a_resp_count;
        fork
            for (int i = 0; i < 6; i++) apply_stimulus_a(vec32[i+4].func, vec32[i+4].data[31:0], vec32[i+4].expected[31:0], 4'(i));
            begin
                repeat (3) @(posedge clk);
                #1 a_resp_ready = 1'b0;
                @(negedge clk);
                check_output("a_stall_req_ready_low", a_req_ready, 1'b0);
                repeat (3) @(posedge clk);
                #1 a_resp_ready = 1'b1;
            end
        join
        drain("stall");
        check_output("a_stall_resp_count", a_resp_count - cnt, 6);

        $display("[TB] async reset with requests in flight on A");
        for (int i = 0; i < 3; i++) apply_stimulus_a(vec32[i].func, vec32[i].data[31:0], vec32[i].expected[31:0], 4'(i));
        check_output("a_pre_reset_valid", a_resp_valid, 1'b1);
        #2;
        rst = 1'b1;
        a_exp_q.delete(); a_id_q.delete(); b_exp_q.delete(); b_id_q.delete();
        #1;
        check_output("a_async_reset_valid", a_resp_valid, 1'b0);
        check_output("a_async_reset_data", a_resp_data, 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        cnt = a_resp_count;
        repeat (6) @(posedge clk);
        #1;
        check_output("a_no_resp_after_reset", a_resp_count - cnt, 0);
        a_req_valid = 1'b1; a_req_func = 2'd1; a_req_data = 32'hFFFFFFFF; a_cur_exp = 32'h003FFFFF; a_req_id = 4'd9;
        @(negedge clk);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("a_post_reset_latency_k%0d", k), a_resp_valid, k == 2);
        end
        @(posedge clk);
        #1;

        $display("[TB] random traffic with random backpressure");
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    f = 2'($urandom_range(0, 3));
                    d32 = $urandom;
                    t = sigma_ref(32, f, {32'h0, d32});
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                    apply_stimulus_a(f, d32, t[31:0], 4'(i));
                end
                for (int i = 0; i < 3000; i++) begin
                    f = 2'($urandom_range(0, 3));
                    d64 = {$urandom, $urandom};
                    t = sigma_ref(64, f, d64);
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                    apply_stimulus_b(f, d64, t, 4'(i));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    a_resp_ready = ($urandom_range(0, 3) != 0);
                    b_resp_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                a_resp_ready = 1'b1;
                b_resp_ready = 1'b1;
            end
        join
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
